// File: rtl/dmem_arb_pkg.sv
// Shared constants and helpers for the data-memory arbiter.
package dmem_arb_pkg;

  parameter int unsigned DATA_W_DEF = 17;

  localparam int unsigned PORT_CORE = 0;
  localparam int unsigned PORT_LOAD = 1;

  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Requester-side bus of the data-memory arbiter: core (port 0) and loader (port 1).
interface dmem_arb_if #(
  parameter int unsigned DATA_W = 17
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [DATA_W-1:0] addr0;
  logic [DATA_W-1:0] addr1;
  logic [DATA_W-1:0] wd0;
  logic [DATA_W-1:0] wd1;
  logic              gnt0;
  logic              gnt1;
  logic              stall0;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              rvalid0;
  logic              rvalid1;
  logic              err;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wd0, wd1,
    input  gnt0, gnt1, stall0, rdata0, rdata1, rvalid0, rvalid1, err
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wd0, wd1,
    output gnt0, gnt1, stall0, rdata0, rdata1, rvalid0, rvalid1, err
  );
endinterface

// File: rtl/dmem_arb_starve.sv
// Saturating count of consecutive cycles port 1 was denied; force1 lets it win.
module dmem_arb_starve #(
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic req1,
  input  logic gnt1,
  output logic force1
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (gnt1 || !req1) begin
      starve_cnt <= '0;
    end else if (starve_cnt < LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force1 = (starve_cnt >= LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority (core first) single-port DataMemory arbiter with starvation
// override, 1-cycle registered read data and address bounds checking.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arb_if.slave         bus,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  logic              force1;
  logic              gnt0;
  logic              gnt1;
  logic              granted;
  logic              we_sel;
  logic              inr;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic              err_q;

  dmem_arb_starve #(
    .STARVE_LIM (STARVE_LIM),
    .CNT_W      (CNT_W)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .req1   (bus.req1),
    .gnt1   (gnt1),
    .force1 (force1)
  );

  // Grants are gated by reset so nothing reaches memory while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (bus.req1 && (!bus.req0 || force1)) begin
        gnt1 = 1'b1;
      end else if (bus.req0) begin
        gnt0 = 1'b1;
      end
    end
  end

  always_comb begin
    granted  = gnt0 | gnt1;
    mem_addr = gnt1 ? bus.addr1 : bus.addr0;
    mem_wd   = gnt1 ? bus.wd1   : bus.wd0;
    we_sel   = gnt1 ? bus.we1   : bus.we0;
    inr      = in_range(32'(mem_addr), DEPTH);
    mem_we   = granted & we_sel & inr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rvalid0_q <= gnt0 & ~bus.we0;
      rvalid1_q <= gnt1 & ~bus.we1;
      err_q     <= granted & ~inr;
      if (gnt0 && !bus.we0) begin
        rdata0_q <= inr ? mem_rd : '0;
      end
      if (gnt1 && !bus.we1) begin
        rdata1_q <= inr ? mem_rd : '0;
      end
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.stall0  = bus.req0 & ~gnt0;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 128-word DataMemory.
module tb_dmem_arbiter;

  localparam int unsigned DW = 17;

  logic          clk;
  logic          reset;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic          mem_we;
  logic [DW-1:0] mem_rd;
  logic [DW-1:0] mem [0:127];

  int checks;
  int errors;

  dmem_arb_if #(.DATA_W(DW)) bus ();

  dmem_arbiter #(
    .DATA_W     (DW),
    .DEPTH      (128),
    .STARVE_LIM (4),
    .CNT_W      (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[6:0]] <= mem_wd;
  end
  assign mem_rd = mem[mem_addr[6:0]];

  task automatic idle();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0  = 1'b0; bus.we1  = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.wd0   = '0;  bus.wd1   = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 17'd10; bus.wd0 = 17'h00155;
    repeat (2) @(negedge clk);
    checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0 got %b want 0", bus.gnt0); end
    checks++; if (bus.rvalid0 !== 1'b0) begin errors++; $display("FAIL reset_rvalid0 got %b want 0", bus.rvalid0); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL release_gnt0 got %b want 1", bus.gnt0); end
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_write_read();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 17'd5; bus.wd0 = 17'h1ABCD;
    #1;
    checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL wr_gnt0 got %b want 1", bus.gnt0); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we got %b want 1", mem_we); end
    checks++; if (mem_addr !== 17'd5) begin errors++; $display("FAIL wr_mem_addr got %h want 5", mem_addr); end
    checks++; if (mem_wd !== 17'h1ABCD) begin errors++; $display("FAIL wr_mem_wd got %h want 1abcd", mem_wd); end
    @(negedge clk);
    idle();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 17'd5;
    #1;
    checks++; if (bus.gnt1 !== 1'b1) begin errors++; $display("FAIL rd1_gnt1 got %b want 1", bus.gnt1); end
    checks++; if (bus.rvalid0 !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid0 got %b want 0", bus.rvalid0); end
    @(negedge clk);
    checks++; if (bus.rvalid1 !== 1'b1) begin errors++; $display("FAIL rd1_rvalid1 got %b want 1", bus.rvalid1); end
    checks++; if (bus.rdata1 !== 17'h1ABCD) begin errors++; $display("FAIL rd1_rdata1 got %h want 1abcd", bus.rdata1); end
    idle();
    @(negedge clk);
    checks++; if (bus.rvalid1 !== 1'b0) begin errors++; $display("FAIL rd1_pulse got %b want 0", bus.rvalid1); end
  endtask

  task automatic test_starvation();
    logic exp1;
    bus.req0 = 1'b1; bus.addr0 = 17'd1;
    bus.req1 = 1'b1; bus.addr1 = 17'd2;
    for (int k = 0; k < 10; k++) begin
      exp1 = (k == 4) || (k == 9);
      #1;
      checks++; if (bus.gnt1 !== exp1) begin errors++; $display("FAIL starve_gnt1 cyc %0d got %b want %b", k, bus.gnt1, exp1); end
      checks++; if (bus.gnt0 !== !exp1) begin errors++; $display("FAIL starve_gnt0 cyc %0d got %b want %b", k, bus.gnt0, !exp1); end
      checks++; if (bus.stall0 !== exp1) begin errors++; $display("FAIL starve_stall0 cyc %0d got %b want %b", k, bus.stall0, exp1); end
      @(negedge clk);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 17'd200; bus.wd1 = 17'h0BEEF;
    #1;
    checks++; if (bus.gnt1 !== 1'b1) begin errors++; $display("FAIL oor_wr_gnt1 got %b want 1", bus.gnt1); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL oor_wr_mem_we got %b want 0", mem_we); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL oor_err_early got %b want 0", bus.err); end
    @(negedge clk);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b want 1", bus.err); end
    checks++; if (mem[72] !== 17'h01048) begin errors++; $display("FAIL oor_mem72 got %h want 01048", mem[72]); end
    bus.we1 = 1'b0;
    @(negedge clk);
    checks++; if (bus.rvalid1 !== 1'b1) begin errors++; $display("FAIL oor_rd_rvalid1 got %b want 1", bus.rvalid1); end
    checks++; if (bus.rdata1 !== 17'h0) begin errors++; $display("FAIL oor_rd_rdata1 got %h want 0", bus.rdata1); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL oor_rd_err got %b want 1", bus.err); end
    idle();
    @(negedge clk);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse got %b want 0", bus.err); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    for (int k = 1; k <= 4; k++) begin
      if (k <= 3) begin
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 17'(k);
      end else begin
        idle();
      end
      @(negedge clk);
      exp = 17'h01000 + 17'(k);
      if (k <= 3) begin
        checks++; if (bus.rvalid0 !== 1'b1) begin errors++; $display("FAIL b2b_rvalid0 %0d got %b want 1", k, bus.rvalid0); end
        checks++; if (bus.rdata0 !== exp) begin errors++; $display("FAIL b2b_rdata0 %0d got %h want %h", k, bus.rdata0, exp); end
      end else begin
        checks++; if (bus.rvalid0 !== 1'b0) begin errors++; $display("FAIL b2b_rvalid0_end got %b want 0", bus.rvalid0); end
        checks++; if (bus.rdata0 !== 17'h01003) begin errors++; $display("FAIL b2b_rdata0_hold got %h want 01003", bus.rdata0); end
      end
    end
  endtask

  task automatic test_reset_inflight();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 17'd4;
    #1;
    checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL abort_gnt0 got %b want 1", bus.gnt0); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err, mem_we} !== 6'b0)
      begin errors++; $display("FAIL abort_flags got %b want 000000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err, mem_we}); end
    checks++; if (bus.rdata0 !== 17'h0) begin errors++; $display("FAIL abort_rdata0 got %h want 0", bus.rdata0); end
    @(negedge clk);
    checks++; if (bus.rvalid0 !== 1'b0) begin errors++; $display("FAIL abort_rvalid0 got %b want 0", bus.rvalid0); end
    checks++; if (bus.rdata1 !== 17'h0) begin errors++; $display("FAIL abort_rdata1 got %h want 0", bus.rdata1); end
    idle();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.rvalid0 !== 1'b0) begin errors++; $display("FAIL abort_no_reissue got %b want 0", bus.rvalid0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 128; i++) mem[i] = 17'h01000 + 17'(i);
    idle();
    test_reset();
    test_write_read();
    test_starvation();
    test_out_of_range();
    test_back_to_back();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port DataMemory between two requesters:
  - port 0: the mips core data port.
  - port 1: a loader/debug master that preloads or inspects data memory.
- Fixed priority to the core, with a starvation counter that forces a port-1 grant after a bounded wait.
- Registers read data to give a fixed 1-cycle read latency.
- Bounds-checks addresses against memory depth.
- Sits between mips/loader and dmem in top.

Parameters:
- DATA_W, 17, data and address width of the data bus.
- DEPTH, 128, number of DataMemory words; valid addresses are 0..DEPTH-1.
- STARVE_LIM, 4, consecutive denied cycles after which port 1 wins over port 0.
- CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIM.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- req0, req1  in  1 each  access request from port 0 / port 1.
- we0, we1  in  1 each  1 = write, 0 = read; meaningful only while the matching req is high.
- addr0, addr1  in  DATA_W each  word address.
- wd0, wd1  in  DATA_W each  write data.
- gnt0, gnt1  out  1 each  combinational grant for the current cycle; one-hot or zero.
- stall0  out  1  req0 & ~gnt0; drives core pipeline stall.
- rdata0, rdata1  out  DATA_W each  registered read data.
- rvalid0, rvalid1  out  1 each  1-cycle pulse; rdata valid.
- err  out  1  registered 1-cycle pulse: a granted access had addr >= DEPTH.
- mem_addr  out  DATA_W  to dmem address.
- mem_wd  out  DATA_W  to dmem wd.
- mem_we  out  1  to dmem we.
- mem_rd  in  DATA_W  from dmem rd; combinational read.

Behaviour:
- Reset (reset=0, async):
  - starve_cnt=0.
  - rdata0/1=0, rvalid0/1=0, err=0.
  - Grants are combinational and therefore 0 for as long as reset is asserted.
  - An in-flight read's rvalid is dropped and never reissued.
- Grant rules, evaluated every cycle:
  - Only req0 -> gnt0. Only req1 -> gnt1. Neither -> no grant.
  - Both request: gnt1 if starve_cnt >= STARVE_LIM, else gnt0.
- Starvation counter (update at clk edge):
  - req1 & ~gnt1 -> increment, saturating at STARVE_LIM.
  - gnt1 or ~req1 -> clear to 0.
- Memory mux:
  - mem_addr/mem_wd follow the granted port.
  - mem_addr/mem_wd hold port 0's values when nothing is granted.
  - mem_we = granted & we_sel & in_range, where in_range = (addr_sel < DEPTH).
- Write: commits at the same clk edge as the grant cycle; no rvalid is produced.
- Read latency is 1 cycle:
  - At the edge, rdataN <= in_range ? mem_rd : 0, and rvalidN <= 1 for the granted port.
  - rdata holds its value until the next read completion on that port.
- Out of range (addr >= DEPTH):
  - Write is suppressed.
  - Read returns 0 with rvalid still asserted.
  - err pulses 1 cycle later.
- Requester contract: hold req/we/addr/wd stable until the cycle gnt is seen. The arbiter performs no queuing.
- Back-to-back: a port may be granted on consecutive cycles. Reads pipeline, so rvalid stays high continuously.
- A read followed by a write to the same address on the next cycle returns the old data.

Decomposition:
- Package dmem_arb_pkg holds:
  - DATA_W default.
  - localparam PORT_CORE=0, PORT_LOAD=1.
  - Function in_range(addr, depth).
- One sub-module: dmem_arb_starve.
  - Contains the saturating starvation counter plus the force-grant compare.
  - Outputs force1.
- Grant logic, mux and response registers stay in dmem_arbiter.

Test Plan:
1. Reset held 0 with req0=1 -> gnt0=0, rvalid0=0, mem_we=0. Release reset; next cycle gnt0=1.
2. Port 0 write: req0=1, we0=1, addr0=5, wd0=0x1ABCD. Then a port-1 read of addr1=5 -> rvalid1 one cycle after gnt1, rdata1=0x1ABCD.
3. req0 and req1 both held high for 10 cycles, STARVE_LIM=4:
   - Cycles 0-3: gnt0.
   - Cycle 4: gnt1, starve_cnt clears.
   - Cycles 5-8: gnt0.
   - Cycle 9: gnt1.
   - stall0=1 exactly on cycles 4 and 9.
4. Port 1 write to addr1=200 (>= DEPTH) -> mem_we=0, err pulses the next cycle, and memory at 200 mod 128 = 72 is unchanged. A read of addr1=200 -> rdata1=0 with rvalid1=1.
5. Port 0 reads addr 1, 2, 3 on consecutive cycles -> rvalid0 high 3 consecutive cycles, rdata0 returns in order.
6. Port 0 read granted, reset asserted before the next edge -> rvalid0 never pulses; all outputs are 0 while reset=0.
